apb_master: RTL and testbench

- APB4 requester (initiator) that drives the timer's APB completer port (tim_psel/tim_penable/tim_pwrite/tim_paddr/tim_pwdata/tim_pstrb, tim_prdata/tim_pready/tim_pslverr).
- Converts a simple valid/ready command channel from a local controller or CPU shim into single APB transfers.
- Returns a response on a valid/ready response channel.
- One transfer outstanding; includes a PREADY timeout watchdog and an alignment check.

---
 rtl/apb_pkg.sv | 29 ++
 rtl/apb_watchdog.sv | 29 ++
 rtl/apb_master.sv | 155 +++++++++++++++
 tb/tb_apb_master.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared definitions for the APB4 requester: FSM states, alignment mask
// and the encoding of why a response carries an error.
package apb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } state_e;

   localparam logic [1:0] APB_ALIGN_MASK = 2'b11;

   typedef enum logic [1:0] {
      CAUSE_NONE    = 2'd0,
      CAUSE_SLVERR  = 2'd1,
      CAUSE_TIMEOUT = 2'd2,
      CAUSE_ALIGN   = 2'd3
   } err_cause_e;

   function automatic logic cause_err(err_cause_e c);
      return c != CAUSE_NONE;
   endfunction

   function automatic logic cause_tmo(err_cause_e c);
      return c == CAUSE_TIMEOUT;
   endfunction

endpackage

// File: rtl/apb_watchdog.sv
// Saturating PREADY wait counter; o_expired flags the last allowed
// ACCESS cycle. TIMEOUT of 0 disables it.
module apb_watchdog
   import apb_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic i_clk,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expired
);

   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] SAT  = CW'(TIMEOUT);
   localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge i_clk) begin
      if (i_clr)
         r_cnt <= '0;
      else if (i_en && (r_cnt != SAT))
         r_cnt <= r_cnt + CW'(1);
   end

   assign o_expired = (TIMEOUT != 0) && (r_cnt == LAST);

endmodule

// File: rtl/apb_master.sv
// APB4 requester: turns a valid/ready command into one APB transfer and
// returns the outcome on a valid/ready response channel.
module apb_master
   import apb_pkg::*;
#(
   parameter int ADDR_W  = 12,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic                sys_clk,
   input  logic                sys_rst,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic                cmd_write,
   input  logic [ADDR_W-1:0]   cmd_addr,
   input  logic [DATA_W-1:0]   cmd_wdata,
   input  logic [DATA_W/8-1:0] cmd_strb,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic                rsp_err,
   output logic                rsp_timeout,
   output logic                m_psel,
   output logic                m_penable,
   output logic                m_pwrite,
   output logic [ADDR_W-1:0]   m_paddr,
   output logic [DATA_W-1:0]   m_pwdata,
   output logic [DATA_W/8-1:0] m_pstrb,
   input  logic [DATA_W-1:0]   m_prdata,
   input  logic                m_pready,
   input  logic                m_pslverr
);

   localparam int SW = DATA_W / 8;

   state_e            r_state;
   logic              r_cmd_ready;
   logic              r_rsp_valid;
   logic [DATA_W-1:0] r_rsp_rdata;
   logic              r_rsp_err;
   logic              r_rsp_timeout;
   logic              r_psel;
   logic              r_penable;
   logic              r_pwrite;
   logic [ADDR_W-1:0] r_paddr;
   logic [DATA_W-1:0] r_pwdata;
   logic [SW-1:0]     r_pstrb;

   logic w_fire;
   logic w_misaligned;
   logic w_wd_clr;
   logic w_wd_en;
   logic w_expired;

   assign w_fire       = cmd_valid && r_cmd_ready;
   assign w_misaligned = |(cmd_addr[1:0] & APB_ALIGN_MASK);
   assign w_wd_clr     = sys_rst || ((r_state == ST_RESP) && rsp_ready);
   assign w_wd_en      = (r_state == ST_ACCESS) && !m_pready;

   apb_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
      .i_clk     (sys_clk),
      .i_clr     (w_wd_clr),
      .i_en      (w_wd_en),
      .o_expired (w_expired)
   );

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         r_state       <= ST_IDLE;
         r_cmd_ready   <= 1'b1;
         r_rsp_valid   <= 1'b0;
         r_rsp_rdata   <= '0;
         r_rsp_err     <= 1'b0;
         r_rsp_timeout <= 1'b0;
         r_psel        <= 1'b0;
         r_penable     <= 1'b0;
         r_pwrite      <= 1'b0;
         r_paddr       <= '0;
         r_pwdata      <= '0;
         r_pstrb       <= '0;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               r_cmd_ready <= 1'b1;
               if (w_fire) begin
                  r_cmd_ready <= 1'b0;
                  if (w_misaligned) begin
                     r_state       <= ST_RESP;
                     r_rsp_valid   <= 1'b1;
                     r_rsp_rdata   <= '0;
                     r_rsp_err     <= cause_err(CAUSE_ALIGN);
                     r_rsp_timeout <= cause_tmo(CAUSE_ALIGN);
                  end else begin
                     r_state   <= ST_SETUP;
                     r_psel    <= 1'b1;
                     r_penable <= 1'b0;
                     r_pwrite  <= cmd_write;
                     r_paddr   <= cmd_addr;
                     r_pwdata  <= cmd_write ? cmd_wdata : '0;
                     r_pstrb   <= cmd_write ? cmd_strb : '0;
                  end
               end
            end
            ST_SETUP: begin
               r_penable <= 1'b1;
               r_state   <= ST_ACCESS;
            end
            ST_ACCESS: begin
               // PREADY wins over a watchdog firing in the same cycle
               if (m_pready) begin
                  r_psel        <= 1'b0;
                  r_penable     <= 1'b0;
                  r_rsp_valid   <= 1'b1;
                  r_rsp_rdata   <= r_pwrite ? '0 : m_prdata;
                  r_rsp_err     <= cause_err(m_pslverr ? CAUSE_SLVERR
                                                       : CAUSE_NONE);
                  r_rsp_timeout <= 1'b0;
                  r_state       <= ST_RESP;
               end else if (w_expired) begin
                  r_psel        <= 1'b0;
                  r_penable     <= 1'b0;
                  r_rsp_valid   <= 1'b1;
                  r_rsp_rdata   <= '0;
                  r_rsp_err     <= cause_err(CAUSE_TIMEOUT);
                  r_rsp_timeout <= cause_tmo(CAUSE_TIMEOUT);
                  r_state       <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  r_rsp_valid   <= 1'b0;
                  r_rsp_rdata   <= '0;
                  r_rsp_err     <= 1'b0;
                  r_rsp_timeout <= 1'b0;
                  r_cmd_ready   <= 1'b1;
                  r_state       <= ST_IDLE;
               end
            end
         endcase
      end
   end

   assign cmd_ready   = r_cmd_ready;
   assign rsp_valid   = r_rsp_valid;
   assign rsp_rdata   = r_rsp_rdata;
   assign rsp_err     = r_rsp_err;
   assign rsp_timeout = r_rsp_timeout;
   assign m_psel      = r_psel;
   assign m_penable   = r_penable;
   assign m_pwrite    = r_pwrite;
   assign m_paddr     = r_paddr;
   assign m_pwdata    = r_pwdata;
   assign m_pstrb     = r_pstrb;

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: directed vector table, reset
// corner sequence and randomized transfers against a reference model.
module tb_apb_master;

   localparam int TO    = 16;
   localparam int LIMIT = 80;

   logic        sys_clk = 1'b0;
   logic        sys_rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [11:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic [3:0]  cmd_strb;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        rsp_timeout;
   logic        m_psel;
   logic        m_penable;
   logic        m_pwrite;
   logic [11:0] m_paddr;
   logic [31:0] m_pwdata;
   logic [3:0]  m_pstrb;
   logic [31:0] m_prdata;
   logic        m_pready;
   logic        m_pslverr;

   int n_checks = 0;
   int n_errors = 0;

   always #5 sys_clk = ~sys_clk;

   apb_master #(.ADDR_W(12), .DATA_W(32), .TIMEOUT(TO)) dut (
      .sys_clk     (sys_clk),
      .sys_rst     (sys_rst),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_write   (cmd_write),
      .cmd_addr    (cmd_addr),
      .cmd_wdata   (cmd_wdata),
      .cmd_strb    (cmd_strb),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_rdata   (rsp_rdata),
      .rsp_err     (rsp_err),
      .rsp_timeout (rsp_timeout),
      .m_psel      (m_psel),
      .m_penable   (m_penable),
      .m_pwrite    (m_pwrite),
      .m_paddr     (m_paddr),
      .m_pwdata    (m_pwdata),
      .m_pstrb     (m_pstrb),
      .m_prdata    (m_prdata),
      .m_pready    (m_pready),
      .m_pslverr   (m_pslverr)
   );

   typedef struct {
      logic        w;
      logic [11:0] a;
      logic [31:0] wd;
      logic [3:0]  st;
      int          waits;
      logic        se;
      logic [31:0] pd;
      int          bp;
      logic        e_err;
      logic        e_to;
      logic [31:0] e_rd;
      int          e_lat;
      int          e_acc;
   } vec_t;

   vec_t tbl[10];

   function void check(string nm, logic [31:0] got, logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endfunction

   // Outcome from the protocol rules: misaligned -> immediate error,
   // slave slower than the watchdog -> timeout after TO ACCESS cycles,
   // otherwise the slave's answer after waits+1 ACCESS cycles.
   task automatic model(input logic w, input logic [11:0] a,
                        input int waits, input logic se,
                        input logic [31:0] pd,
                        output logic e_err, output logic e_to,
                        output logic [31:0] e_rd,
                        output int e_lat, output int e_acc);
      if (a % 4 != 0) begin
         e_err = 1'b1; e_to = 1'b0; e_rd = '0;
         e_acc = 0;    e_lat = 1;
      end else if (TO != 0 && waits >= TO) begin
         e_err = 1'b1; e_to = 1'b1; e_rd = '0;
         e_acc = TO;   e_lat = 2 + TO;
      end else begin
         e_err = se;   e_to = 1'b0; e_rd = w ? 32'h0 : pd;
         e_acc = waits + 1;
         e_lat = 2 + e_acc;
      end
   endtask

   task automatic xfer(input vec_t v, input string nm);
      int acc, first_sel, first_rsp;
      logic done, bad_busy, bad_apb, bad_hold, bad_sel;
      logic [31:0] h_rd;
      logic h_err, h_to;
      acc = 0; first_sel = -1; first_rsp = -1; done = 1'b0;
      bad_busy = 0; bad_apb = 0; bad_hold = 0; bad_sel = 0;
      h_rd = '0; h_err = 0; h_to = 0;
      @(negedge sys_clk);
      check({nm, ".idle_ready"}, 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b1;
      cmd_write = v.w;
      cmd_addr  = v.a;
      cmd_wdata = v.wd;
      cmd_strb  = v.st;
      rsp_ready = 1'b0;
      m_pready  = 1'b0;
      m_pslverr = 1'b0;
      for (int c = 1; c <= LIMIT && !done; c++) begin
         @(negedge sys_clk);
         cmd_valid = 1'b0;
         cmd_write = 1'($urandom);
         cmd_addr  = 12'($urandom);
         cmd_wdata = $urandom;
         cmd_strb  = 4'($urandom);
         if (first_rsp >= 0 && rsp_ready) begin
            done = 1'b1;
            check({nm, ".end_cycle"}, 32'(c), 32'(first_rsp + v.bp + 1));
            check({nm, ".ready_back"}, 32'(cmd_ready), 32'd1);
            check({nm, ".rsp_drop"}, 32'(rsp_valid), 32'd0);
            rsp_ready = 1'b0;
            m_pready  = 1'b0;
            m_pslverr = 1'b0;
         end else begin
            if (cmd_ready) bad_busy = 1'b1;
            m_pready  = 1'b0;
            m_pslverr = 1'b0;
            m_prdata  = $urandom;
            if (m_psel) begin
               if (first_sel < 0) first_sel = c;
               if (m_paddr !== v.a || m_pwrite !== v.w ||
                   m_pstrb !== (v.w ? v.st : 4'h0) ||
                   m_pwdata !== (v.w ? v.wd : 32'h0))
                  bad_apb = 1'b1;
               if (m_penable) begin
                  acc++;
                  if (acc == v.waits + 1) begin
                     m_pready  = 1'b1;
                     m_pslverr = v.se;
                     m_prdata  = v.pd;
                  end
               end else if (c != first_sel) begin
                  bad_apb = 1'b1;
               end
            end else if (m_penable) begin
               bad_apb = 1'b1;
            end
            if (rsp_valid) begin
               if (m_psel) bad_sel = 1'b1;
               if (first_rsp < 0) begin
                  first_rsp = c;
                  h_rd = rsp_rdata; h_err = rsp_err; h_to = rsp_timeout;
               end else if (rsp_rdata !== h_rd || rsp_err !== h_err ||
                            rsp_timeout !== h_to) begin
                  bad_hold = 1'b1;
               end
               rsp_ready = (c - first_rsp >= v.bp);
            end
         end
      end
      check({nm, ".finished"}, 32'(done), 32'd1);
      check({nm, ".first_psel"}, 32'(first_sel),
            (v.e_acc > 0) ? 32'd1 : 32'hFFFF_FFFF);
      check({nm, ".access_cycles"}, 32'(acc), 32'(v.e_acc));
      check({nm, ".rsp_latency"}, 32'(first_rsp), 32'(v.e_lat));
      check({nm, ".rsp_err"}, 32'(h_err), 32'(v.e_err));
      check({nm, ".rsp_timeout"}, 32'(h_to), 32'(v.e_to));
      check({nm, ".rsp_rdata"}, h_rd, v.e_rd);
      check({nm, ".apb_signals"}, 32'(bad_apb), 32'd0);
      check({nm, ".busy_not_ready"}, 32'(bad_busy), 32'd0);
      check({nm, ".rsp_stable"}, 32'(bad_hold), 32'd0);
      check({nm, ".bus_idle_in_resp"}, 32'(bad_sel), 32'd0);
   endtask

   initial begin
      vec_t v;
      sys_rst   = 1'b1;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = '0;
      cmd_wdata = '0;
      cmd_strb  = '0;
      rsp_ready = 1'b0;
      m_prdata  = '0;
      m_pready  = 1'b0;
      m_pslverr = 1'b0;

      //          w   addr     wdata         strb  wt  se  prdata      bp   err to  rdata         lat acc
      tbl[0] = '{1'b1, 12'h004, 32'h0000_00AB, 4'hF, 0, 1'b0, 32'h0,       0, 1'b0, 1'b0, 32'h0,       3, 1};
      tbl[1] = '{1'b0, 12'h010, 32'h0,         4'h0, 3, 1'b0, 32'hDEADBEEF, 0, 1'b0, 1'b0, 32'hDEADBEEF, 6, 4};
      tbl[2] = '{1'b1, 12'hFFC, 32'h1234_5678, 4'h3, 0, 1'b1, 32'h0,       0, 1'b1, 1'b0, 32'h0,       3, 1};
      tbl[3] = '{1'b0, 12'h020, 32'h0,         4'h0, 16, 1'b0, 32'h11111111, 0, 1'b1, 1'b1, 32'h0,      18, 16};
      tbl[4] = '{1'b0, 12'h024, 32'h0,         4'h0, 15, 1'b0, 32'h12345678, 0, 1'b0, 1'b0, 32'h12345678, 18, 16};
      tbl[5] = '{1'b1, 12'h006, 32'h0000_0077, 4'hF, 0, 1'b0, 32'h0,       0, 1'b1, 1'b0, 32'h0,       1, 0};
      tbl[6] = '{1'b0, 12'h030, 32'h0,         4'h0, 2, 1'b1, 32'hCAFEF00D, 0, 1'b1, 1'b0, 32'hCAFEF00D, 5, 3};
      tbl[7] = '{1'b1, 12'h008, 32'h0000_55AA, 4'h5, 1, 1'b0, 32'h0,       5, 1'b0, 1'b0, 32'h0,       4, 2};
      tbl[8] = '{1'b0, 12'h001, 32'h0,         4'h0, 0, 1'b0, 32'h9999,    0, 1'b1, 1'b0, 32'h0,       1, 0};
      tbl[9] = '{1'b1, 12'h7F0, 32'hA5A5_A5A5, 4'h0, 20, 1'b0, 32'h0,      2, 1'b1, 1'b1, 32'h0,      18, 16};

      repeat (3) @(negedge sys_clk);
      check("rst.psel", 32'(m_psel), 32'd0);
      check("rst.penable", 32'(m_penable), 32'd0);
      check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst.rsp_err", 32'(rsp_err), 32'd0);
      check("rst.pstrb", 32'(m_pstrb), 32'd0);
      sys_rst = 1'b0;
      @(negedge sys_clk);
      check("rst.cmd_ready_after", 32'(cmd_ready), 32'd1);

      for (int i = 0; i < 10; i++)
         xfer(tbl[i], $sformatf("vec%0d", i));

      // Reset while stuck in ACCESS, then prove the watchdog restarted
      @(negedge sys_clk);
      cmd_valid = 1'b1;
      cmd_write = 1'b0;
      cmd_addr  = 12'h040;
      m_pready  = 1'b0;
      @(negedge sys_clk);
      cmd_valid = 1'b0;
      repeat (5) @(negedge sys_clk);
      check("midrst.in_access", 32'({m_psel, m_penable}), 32'd3);
      sys_rst = 1'b1;
      @(negedge sys_clk);
      check("midrst.psel", 32'(m_psel), 32'd0);
      check("midrst.penable", 32'(m_penable), 32'd0);
      check("midrst.rsp_valid", 32'(rsp_valid), 32'd0);
      sys_rst = 1'b0;
      @(negedge sys_clk);
      check("midrst.cmd_ready", 32'(cmd_ready), 32'd1);
      xfer(tbl[3], "post_rst_timeout");

      for (int i = 0; i < 40; i++) begin
         int r;
         v.w  = 1'($urandom);
         v.a  = 12'($urandom) & 12'hFFC;
         if ($urandom_range(0, 3) == 0)
            v.a[1:0] = 2'($urandom_range(1, 3));
         v.wd = $urandom;
         v.st = 4'($urandom);
         r = int'($urandom_range(0, 9));
         v.waits = (r < 7) ? (r % 4) : (13 + (r - 7) * 2);
         v.se = 1'($urandom);
         v.pd = $urandom;
         v.bp = int'($urandom_range(0, 3));
         model(v.w, v.a, v.waits, v.se, v.pd,
               v.e_err, v.e_to, v.e_rd, v.e_lat, v.e_acc);
         xfer(v, $sformatf("rand%0d", i));
      end

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
